xtx_accum_ctrl: RTL and testbench

//  Sequencer for the X^T X / X^T Y accumulation stage of the simple linear-regression engine.
//  - Streams N samples (x,y) over a valid/ready handshake.
//  - Time-shares one pipelined signed multiplier between the x*x and x*y products.
//  - Accumulates the four sums needed for the 2x2 normal equations: sum_x, sum_y, sum_xx, sum_xy.
//  - Presents the sums to the solver stage with a one-cycle done pulse.

---
 rtl/xtx_accum_ctrl_pkg.sv | 18 +
 rtl/xtx_accum_ctrl_pipe_mul.sv | 50 +++++
 rtl/xtx_accum_ctrl.sv | 162 ++++++++++++++++
 tb/tb_xtx_accum_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/xtx_accum_ctrl_pkg.sv
// Shared definitions for the X^T X / X^T Y accumulation sequencer.
// Holds the state encoding, the Q16.16 format constant and the default widths.
package xtx_accum_ctrl_pkg;

    localparam int FRAC_BITS = 16;
    localparam int DEF_DW    = 32;
    localparam int DEF_AW    = 64;
    localparam int DEF_NW    = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCEPT = 3'd1,
        ST_ISSUE2 = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/xtx_accum_ctrl_pipe_mul.sv
// Pipelined signed DW x DW multiplier with a valid bit and a one-bit tag
// carried alongside the data, so products retire in issue order.
module pipe_mul #(
    parameter int DW      = 32,
    parameter int MUL_LAT = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic                   in_tag,
    input  logic signed [DW-1:0]   in_a,
    input  logic signed [DW-1:0]   in_b,
    output logic                   out_valid,
    output logic                   out_tag,
    output logic signed [2*DW-1:0] out_p,
    output logic                   in_flight
);

    logic signed [2*DW-1:0] p_q [MUL_LAT];
    logic [MUL_LAT-1:0]     v_q;
    logic [MUL_LAT-1:0]     t_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_q <= '0;
            t_q <= '0;
            for (int i = 0; i < MUL_LAT; i++) p_q[i] <= '0;
        end else begin
            v_q[0] <= in_valid;
            t_q[0] <= in_tag;
            p_q[0] <= (2*DW)'(in_a) * (2*DW)'(in_b);
            for (int i = 1; i < MUL_LAT; i++) begin
                v_q[i] <= v_q[i-1];
                t_q[i] <= t_q[i-1];
                p_q[i] <= p_q[i-1];
            end
        end
    end

    assign out_valid = v_q[MUL_LAT-1];
    assign out_tag   = t_q[MUL_LAT-1];
    assign out_p     = p_q[MUL_LAT-1];

    // The last stage retires this cycle, so it does not count as still in flight.
    always_comb begin
        in_flight = 1'b0;
        for (int i = 0; i < MUL_LAT - 1; i++) in_flight = in_flight | v_q[i];
    end

endmodule

// File: rtl/xtx_accum_ctrl.sv
// Sequencer that streams (x,y) samples, time-shares one multiplier between
// x*x and x*y, and accumulates sum_x, sum_y, sum_xx and sum_xy for the solver.
//
//  state  | meaning
//  IDLE   | waiting for start; sums hold last result
//  ACCEPT | s_ready high, waiting for a sample; issues x*x on handshake
//  ISSUE2 | issues x*y for the registered sample, counts it off
//  DRAIN  | waiting for outstanding products to retire
//  DONE   | one-cycle done pulse
module xtx_accum_ctrl
    import xtx_accum_ctrl_pkg::*;
#(
    parameter int DW      = DEF_DW,
    parameter int AW      = DEF_AW,
    parameter int NW      = DEF_NW,
    parameter int MUL_LAT = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [NW-1:0]        n_samples,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic signed [DW-1:0] s_x,
    input  logic signed [DW-1:0] s_y,
    output logic                 busy,
    output logic                 done,
    output logic [NW-1:0]        sum_n,
    output logic [AW-1:0]        sum_x,
    output logic [AW-1:0]        sum_y,
    output logic [AW-1:0]        sum_xx,
    output logic [AW-1:0]        sum_xy
);

    state_t                 state;
    logic [NW-1:0]          remain;
    logic signed [DW-1:0]   x_q;
    logic signed [DW-1:0]   y_q;

    logic                   hs;
    logic                   mul_valid;
    logic                   mul_tag;
    logic signed [DW-1:0]   mul_a;
    logic signed [DW-1:0]   mul_b;
    logic                   ret_valid;
    logic                   ret_tag;
    logic signed [2*DW-1:0] ret_p;
    logic                   in_flight;

    assign hs = s_valid & s_ready;

    always_comb begin
        mul_valid = 1'b0;
        mul_tag   = 1'b0;
        mul_a     = s_x;
        mul_b     = s_x;
        if (state == ST_ISSUE2) begin
            mul_valid = 1'b1;
            mul_tag   = 1'b1;
            mul_a     = x_q;
            mul_b     = y_q;
        end else if (hs) begin
            mul_valid = 1'b1;
        end
    end

    pipe_mul #(
        .DW      (DW),
        .MUL_LAT (MUL_LAT)
    ) u_mul (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (mul_valid),
        .in_tag    (mul_tag),
        .in_a      (mul_a),
        .in_b      (mul_b),
        .out_valid (ret_valid),
        .out_tag   (ret_tag),
        .out_p     (ret_p),
        .in_flight (in_flight)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            remain  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            s_ready <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum_n   <= '0;
            sum_x   <= '0;
            sum_y   <= '0;
            sum_xx  <= '0;
            sum_xy  <= '0;
        end else begin
            done <= 1'b0;
            // Retire runs independently of the FSM so it never blocks a handshake.
            if (ret_valid) begin
                if (ret_tag) sum_xy <= sum_xy + AW'(ret_p);
                else         sum_xx <= sum_xx + AW'(ret_p);
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        sum_n  <= '0;
                        sum_x  <= '0;
                        sum_y  <= '0;
                        sum_xx <= '0;
                        sum_xy <= '0;
                        remain <= n_samples;
                        busy   <= 1'b1;
                        if (n_samples == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state   <= ST_ACCEPT;
                            s_ready <= 1'b1;
                        end
                    end
                end
                ST_ACCEPT: begin
                    if (hs) begin
                        sum_x   <= sum_x + AW'(s_x);
                        sum_y   <= sum_y + AW'(s_y);
                        sum_n   <= sum_n + NW'(1);
                        x_q     <= s_x;
                        y_q     <= s_y;
                        s_ready <= 1'b0;
                        state   <= ST_ISSUE2;
                    end
                end
                ST_ISSUE2: begin
                    remain <= remain - NW'(1);
                    if (remain == NW'(1)) begin
                        state <= ST_DRAIN;
                    end else begin
                        state   <= ST_ACCEPT;
                        s_ready <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (!in_flight) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state   <= ST_IDLE;
                    s_ready <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xtx_accum_ctrl.sv
// Randomised and directed bench for xtx_accum_ctrl against a sample-level model.
module tb_xtx_accum_ctrl;
    import xtx_accum_ctrl_pkg::*;

    localparam int ML = 3;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               start = 1'b0;
    logic [15:0]        n_samples = '0;
    logic               s_valid = 1'b0;
    logic               s_ready;
    logic signed [31:0] s_x = '0;
    logic signed [31:0] s_y = '0;
    logic               busy;
    logic               done;
    logic [15:0]        sum_n;
    logic [63:0]        sum_x;
    logic [63:0]        sum_y;
    logic [63:0]        sum_xx;
    logic [63:0]        sum_xy;

    int pass_cnt = 0;
    int total_cnt = 0;

    xtx_accum_ctrl #(.DW(32), .AW(64), .NW(16), .MUL_LAT(ML)) dut (
        .clk(clk), .reset(reset), .start(start), .n_samples(n_samples),
        .s_valid(s_valid), .s_ready(s_ready), .s_x(s_x), .s_y(s_y),
        .busy(busy), .done(done), .sum_n(sum_n), .sum_x(sum_x),
        .sum_y(sum_y), .sum_xx(sum_xx), .sum_xy(sum_xy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Model: sample-level expectations (sums, busy window, ready cadence, done time).
    int          cyc = 0;
    longint      m_x, m_y, m_xx, m_xy;
    logic [15:0] m_n;
    int          m_target, m_got;
    bit          m_busy, m_ready;
    int          m_done_at = -1;
    int          m_raise_at = -1;
    int          last_hs_cyc, done_cyc, start_cyc, done_cnt = 0;
    bit          rdy_log[$];

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            m_x = 0; m_y = 0; m_xx = 0; m_xy = 0; m_n = 0;
            m_busy = 0; m_ready = 0; m_done_at = -1; m_raise_at = -1;
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_ready", s_ready, 0);
            chk("rst_sums", sum_x | sum_y | sum_xx | sum_xy | 64'(sum_n), 0);
        end else begin
            chk("busy", busy, m_busy);
            chk("s_ready", s_ready, m_ready);
            chk("done", done, cyc == m_done_at);
            if (!m_busy || cyc == m_done_at) begin
                chk("sum_n", sum_n, m_n);
                chk("sum_x", sum_x, m_x);
                chk("sum_y", sum_y, m_y);
                chk("sum_xx", sum_xx, m_xx);
                chk("sum_xy", sum_xy, m_xy);
            end
            if (m_busy) rdy_log.push_back(s_ready);
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (m_busy && cyc == m_done_at) begin
                m_busy = 0; m_ready = 0; m_done_at = -1;
            end else if (!m_busy) begin
                if (start) begin
                    m_x = 0; m_y = 0; m_xx = 0; m_xy = 0; m_n = 0;
                    m_target = n_samples; m_got = 0; m_busy = 1;
                    start_cyc = cyc;
                    rdy_log.delete();
                    if (n_samples == 0) m_done_at = cyc + 1;
                    else m_ready = 1;
                end
            end else if (m_ready && s_valid) begin
                longint xs, ys;
                xs = longint'(s_x);
                ys = longint'(s_y);
                m_x += xs; m_y += ys; m_xx += xs * xs; m_xy += xs * ys;
                m_n = m_n + 16'd1;
                m_got++;
                m_ready = 0;
                last_hs_cyc = cyc;
                if (m_got == m_target) m_done_at = cyc + ML + 2;
                else m_raise_at = cyc + 1;
            end else if (cyc == m_raise_at) begin
                m_ready = 1;
            end
        end
    end

    function automatic logic [31:0] q(input int v);
        return 32'(v) << FRAC_BITS;
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic pulse_start(input int n);
        start = 1'b1; n_samples = 16'(n);
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [31:0] x, input logic [31:0] y, input int gap, input bit drop);
        bit got;
        if (gap > 0) s_valid = 1'b0;
        repeat (gap) tick();
        s_valid = 1'b1; s_x = x; s_y = y;
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (s_ready) got = 1;
            tick();
        end
        if (!got) chk("hs_timeout", 0, 1);
        if (drop) s_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit got;
        got = 0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1;
            tick();
        end
        if (!got) chk("done_timeout", 0, 1);
    endtask

    task automatic run(input int n, input logic [31:0] xs[8], input logic [31:0] ys[8],
                       input bit hold, input int maxgap);
        pulse_start(n);
        for (int i = 0; i < n; i++)
            send(xs[i], ys[i], hold ? 0 : int'($urandom_range(0, maxgap)), !hold || i == n - 1);
        s_valid = 1'b0;
        wait_done();
    endtask

    initial begin
        logic [31:0] xs[8];
        logic [31:0] ys[8];
        logic [6:0]  pat;
        int          ones, dc;

        repeat (3) tick();
        reset = 1'b0;
        tick();

        // 1: single sample
        xs[0] = q(2); ys[0] = q(3);
        run(1, xs, ys, 1, 0);
        chk("t1_sum_x", sum_x, 64'h20000);
        chk("t1_sum_y", sum_y, 64'h30000);
        chk("t1_sum_xx", sum_xx, 64'h4_0000_0000);
        chk("t1_sum_xy", sum_xy, 64'h6_0000_0000);
        chk("t1_sum_n", sum_n, 1);
        chk("t1_latency", done_cyc - last_hs_cyc, 5);

        // 2: four samples, valid held high
        for (int i = 0; i < 4; i++) begin xs[i] = q(i + 1); ys[i] = q(2 * (i + 1)); end
        run(4, xs, ys, 1, 0);
        pat = '0;
        if (rdy_log.size() >= 7) for (int i = 0; i < 7; i++) pat[6-i] = rdy_log[i];
        chk("t2_ready_pat", pat, 7'b1010101);
        chk("t2_sum_x", sum_x, 64'hA0000);
        chk("t2_sum_y", sum_y, 64'h140000);
        chk("t2_sum_xx", sum_xx, 64'h1E_0000_0000);
        chk("t2_sum_xy", sum_xy, 64'h3C_0000_0000);

        // 3: negative operand
        xs[0] = 32'hFFFE8000; ys[0] = q(2);
        run(1, xs, ys, 1, 0);
        chk("t3_sum_xx", sum_xx, 64'h2_4000_0000);
        chk("t3_sum_xy", sum_xy, 64'hFFFF_FFFD_0000_0000);
        chk("t3_sum_x", sum_x, 64'hFFFF_FFFF_FFFE_8000);

        // 4: empty run
        run(0, xs, ys, 1, 0);
        chk("t4_latency", done_cyc - start_cyc, 1);
        ones = 0;
        foreach (rdy_log[i]) ones += int'(rdy_log[i]);
        chk("t4_ready_high", ones, 0);
        chk("t4_sum_xx", sum_xx, 0);

        // 5: reset mid-run aborts without done
        dc = done_cnt;
        pulse_start(4);
        send(q(5), q(6), 0, 1);
        send(q(7), q(8), 1, 1);
        reset = 1'b1;
        tick(); tick();
        chk("t5_sum_x", sum_x, 0);
        reset = 1'b0;
        repeat (8) tick();
        chk("t5_no_done", done_cnt, dc);
        xs[0] = q(1); ys[0] = q(1);
        run(1, xs, ys, 1, 0);
        chk("t5_sum_xy", sum_xy, 64'h1_0000_0000);

        // 6: gaps plus a start while busy
        pulse_start(3);
        send(q(1), q(-1), 2, 1);
        start = 1'b1; n_samples = 16'd7;
        tick();
        start = 1'b0;
        send(q(2), q(4), 2, 1);
        send(q(-3), q(5), 2, 1);
        wait_done();
        tick();
        chk("t6_sum_n", sum_n, 3);
        chk("t6_idle", busy, 0);

        // random runs
        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < 8; i++) begin
                xs[i] = ($urandom_range(0, 1) == 1) ? $urandom : q(int'($urandom_range(0, 20)) - 10);
                ys[i] = ($urandom_range(0, 1) == 1) ? $urandom : q(int'($urandom_range(0, 20)) - 10);
            end
            run(int'($urandom_range(0, 6)), xs, ys, $urandom_range(0, 1) == 1, 3);
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
